// File: rtl/router_port_arbiter_pkg.sv
// Shared NoC arbiter definitions: default sizes, FSM state encoding and port numbering.
package noc_arb_pkg;
  localparam int NREQ_DEF = 5;
  localparam int DW_DEF   = 8;
  localparam int PIDX_W   = $clog2(NREQ_DEF);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_e;
  typedef logic [PIDX_W-1:0] port_idx_t;

  localparam port_idx_t DIR_00    = 3'd0;
  localparam port_idx_t DIR_01    = 3'd1;
  localparam port_idx_t DIR_10    = 3'd2;
  localparam port_idx_t DIR_11    = 3'd3;
  localparam port_idx_t PORT_CORE = 3'd4;

  // Modulo-n increment; n need not be a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/router_port_arbiter_if.sv
// Flit bus between NREQ requesters and one output: per-requester flit inputs, single registered output.
interface router_port_arbiter_if import noc_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    in_valid;
  logic [NREQ*DW-1:0] in_data;
  logic [NREQ-1:0]    in_last;
  logic [NREQ-1:0]    in_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic               out_last;
  logic               out_ready;
  logic [IW-1:0]      grant_id;
  logic               busy;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, grant_id, busy
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, grant_id, busy
  );
endinterface

// File: rtl/router_port_arbiter_rr_pick.sv
// Cyclic first-one finder: lowest set request at or above i_ptr, wrapping at NREQ.
module rr_pick import noc_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_found,
  output logic [IW-1:0]   o_idx
);
  always_comb begin
    int j;
    j       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!o_found && i_req[j]) begin
        o_found = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/router_port_arbiter.sv
// Packet-locked round-robin arbiter: one owner holds the output until its tail flit is accepted.
module router_port_arbiter import noc_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  router_port_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_rr_ptr;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic            r_out_last;

  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic            w_out_free;
  logic            w_acc;
  logic [DW-1:0]   w_own_data;
  logic            w_own_last;
  logic [NREQ-1:0] w_in_ready;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (bus.in_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  // Output slot is free when empty or draining this cycle: full throughput.
  assign w_out_free = !r_out_valid || bus.out_ready;
  assign w_acc      = (r_state == LOCKED) && bus.in_valid[r_owner] && w_out_free;
  assign w_own_data = bus.in_data[r_owner*DW +: DW];
  assign w_own_last = bus.in_last[r_owner];

  always_comb begin
    w_in_ready = '0;
    if (r_state == LOCKED && w_out_free) w_in_ready[r_owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_own_data;
        r_out_last  <= w_own_last;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        IDLE: if (w_found) begin
          r_owner <= w_pick;
          r_state <= LOCKED;
        end
        // An idle owner keeps the lock indefinitely; no timeout.
        LOCKED: if (w_acc && w_own_last) begin
          r_rr_ptr <= IW'(wrap_inc(int'(r_owner), NREQ));
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.grant_id  = r_owner;
  assign bus.busy      = (r_state == LOCKED);
endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed vector bench for router_port_arbiter: table of per-cycle stimulus/expectation plus corner sequences.
module tb_router_port_arbiter;
  import noc_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  router_port_arbiter_if #(.NREQ(5), .DW(8)) bus ();

  router_port_arbiter #(.NREQ(5), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  v;
    logic [39:0] d;
    logic [4:0]  l;
    logic        ordy;
    logic        ov;
    logic [7:0]  od;
    logic        ol;
    logic        bsy;
    logic [2:0]  gid;
    logic [4:0]  inr;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;
  int   checks = 0;
  int   errors = 0;
  int   cur = 0;

  function automatic logic [39:0] D(input port_idx_t p, input logic [7:0] b);
    logic [39:0] r;
    r = '0;
    r[int'(p)*8 +: 8] = b;
    return r;
  endfunction

  task automatic add(input logic rst, input logic [4:0] v, input logic [39:0] d, input logic [4:0] l,
                     input logic ordy, input logic ov, input logic [7:0] od, input logic ol,
                     input logic bsy, input logic [2:0] gid, input logic [4:0] inr);
    vecs[nvec] = '{rst, v, d, l, ordy, ov, od, ol, bsy, gid, inr};
    nvec++;
  endtask

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %h expected %h", nm, cur, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v, input logic [39:0] d, input logic [4:0] l, input logic ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
  endtask

  task automatic check_reset_outs();
    chk("rst_out_valid", 40'(bus.out_valid), 40'd0);
    chk("rst_busy",      40'(bus.busy),      40'd0);
    chk("rst_in_ready",  40'(bus.in_ready),  40'd0);
    chk("rst_grant_id",  40'(bus.grant_id),  40'd0);
    chk("rst_out_data",  40'(bus.out_data),  40'd0);
    chk("rst_out_last",  40'(bus.out_last),  40'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive('0, '0, '0, 1'b1);
    rst_n = 1'b0;
    #2;
    check_reset_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic apply_vec(input vec_t t);
    if (t.rst) do_reset();
    drive(t.v, t.d, t.l, t.ordy);
    @(posedge clk); #1;
    chk("out_valid", 40'(bus.out_valid), 40'(t.ov));
    if (t.ov) begin
      chk("out_data", 40'(bus.out_data), 40'(t.od));
      chk("out_last", 40'(bus.out_last), 40'(t.ol));
    end
    chk("busy", 40'(bus.busy), 40'(t.bsy));
    if (t.bsy) chk("grant_id", 40'(bus.grant_id), 40'(t.gid));
    chk("in_ready", 40'(bus.in_ready), 40'(t.inr));
    cur++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t;
    drive('0, '0, '0, 1'b1);

    // 3-flit packet from port 0 with free-flowing output.
    add(1, 5'b00001, D(DIR_00, 8'h11), 5'b00000, 1, 0, 8'h00, 0, 1, 3'd0, 5'b00001);
    add(0, 5'b00001, D(DIR_00, 8'h11), 5'b00000, 1, 1, 8'h11, 0, 1, 3'd0, 5'b00001);
    add(0, 5'b00001, D(DIR_00, 8'h22), 5'b00000, 1, 1, 8'h22, 0, 1, 3'd0, 5'b00001);
    add(0, 5'b00001, D(DIR_00, 8'h33), 5'b00001, 1, 1, 8'h33, 1, 0, 3'd0, 5'b00000);
    add(0, 5'b00000, 40'd0,            5'b00000, 1, 0, 8'h00, 0, 0, 3'd0, 5'b00000);
    // Port 2 holds the lock while port 3 waits; port 3 granted next.
    add(1, 5'b00100, D(DIR_10, 8'h20), 5'b00000, 1, 0, 8'h00, 0, 1, 3'd2, 5'b00100);
    add(0, 5'b01100, D(DIR_10, 8'h20) | D(DIR_11, 8'h30), 5'b00000, 1, 1, 8'h20, 0, 1, 3'd2, 5'b00100);
    add(0, 5'b01100, D(DIR_10, 8'h21) | D(DIR_11, 8'h30), 5'b00100, 1, 1, 8'h21, 1, 0, 3'd0, 5'b00000);
    add(0, 5'b01000, D(DIR_11, 8'h30), 5'b01000, 1, 0, 8'h00, 0, 1, 3'd3, 5'b01000);
    add(0, 5'b01000, D(DIR_11, 8'h30), 5'b01000, 1, 1, 8'h30, 1, 0, 3'd0, 5'b00000);
    add(0, 5'b00000, 40'd0,            5'b00000, 1, 0, 8'h00, 0, 0, 3'd0, 5'b00000);
    // Backpressure: 0xA5 held four cycles, then 0xB6 accepted exactly once.
    add(1, 5'b00001, D(DIR_00, 8'hA5), 5'b00000, 1, 0, 8'h00, 0, 1, 3'd0, 5'b00001);
    add(0, 5'b00001, D(DIR_00, 8'hA5), 5'b00000, 1, 1, 8'hA5, 0, 1, 3'd0, 5'b00001);
    for (int i = 0; i < 4; i++)
      add(0, 5'b00001, D(DIR_00, 8'hB6), 5'b00001, 0, 1, 8'hA5, 0, 1, 3'd0, 5'b00000);
    add(0, 5'b00001, D(DIR_00, 8'hB6), 5'b00001, 1, 1, 8'hB6, 1, 0, 3'd0, 5'b00000);
    add(0, 5'b00000, 40'd0,            5'b00000, 1, 0, 8'h00, 0, 0, 3'd0, 5'b00000);
    // Owner 0 drops valid for 3 cycles while everyone else requests.
    add(1, 5'b11111, D(DIR_00, 8'h40), 5'b11110, 1, 0, 8'h00, 0, 1, 3'd0, 5'b00001);
    add(0, 5'b11111, D(DIR_00, 8'h40), 5'b11110, 1, 1, 8'h40, 0, 1, 3'd0, 5'b00001);
    for (int i = 0; i < 3; i++)
      add(0, 5'b11110, D(DIR_00, 8'h40), 5'b11110, 1, 0, 8'h00, 0, 1, 3'd0, 5'b00001);
    add(0, 5'b11111, D(DIR_00, 8'h41), 5'b11111, 1, 1, 8'h41, 1, 0, 3'd0, 5'b00000);
    add(0, 5'b11110, D(DIR_01, 8'h51), 5'b11110, 1, 0, 8'h00, 0, 1, 3'd1, 5'b00010);
    add(0, 5'b11110, D(DIR_01, 8'h51), 5'b11110, 1, 1, 8'h51, 1, 0, 3'd0, 5'b00000);

    for (int i = 0; i < nvec; i++) apply_vec(vecs[i]);

    // All five requesters with single-flit packets: grant order 0..4 then wrap to 0.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      int p;
      logic [39:0] dd;
      p  = k % 5;
      dd = '0;
      for (int q = 0; q < 5; q++) dd |= D(port_idx_t'(q), 8'hC0 + 8'(q));
      t = '{0, 5'b11111, dd, 5'b11111, 1, 0, 8'h00, 0, 1, 3'(p), 5'(1 << p)};
      apply_vec(t);
      t = '{0, 5'b11111, dd, 5'b11111, 1, 1, 8'hC0 + 8'(p), 1, 0, 3'd0, 5'b00000};
      apply_vec(t);
    end

    // Reset mid-packet after rr_ptr has advanced: requester 0 must win afterwards.
    do_reset();
    apply_vec('{0, 5'b00100, D(DIR_10, 8'h66), 5'b00100, 1, 0, 8'h00, 0, 1, 3'd2, 5'b00100});
    apply_vec('{0, 5'b00100, D(DIR_10, 8'h66), 5'b00100, 1, 1, 8'h66, 1, 0, 3'd0, 5'b00000});
    apply_vec('{0, 5'b01000, D(DIR_11, 8'h77), 5'b00000, 1, 0, 8'h00, 0, 1, 3'd3, 5'b01000});
    apply_vec('{0, 5'b01000, D(DIR_11, 8'h77), 5'b00000, 1, 1, 8'h77, 0, 1, 3'd3, 5'b01000});
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply_vec('{0, 5'b11111, D(PORT_CORE, 8'h99), 5'b11111, 1, 0, 8'h00, 0, 1, 3'd0, 5'b00001});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
